// File: rtl/onchip_ram_pkg.sv
// Shared constants and types for the two-requester on-chip RAM arbiter.
// The RAM is 5120 words deep but addressed with 13 bits, so the range check matters.
package onchip_ram_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 5120;

   typedef enum logic {
      PORT_M0 = 1'b0,
      PORT_M1 = 1'b1
   } port_e;

   typedef struct packed {
      logic  vld;
      port_e port;
      logic  oor;
   } rd_tag_t;

   // True when the word address lies beyond the populated RAM depth.
   function automatic logic addr_oor(input logic [ADDR_W-1:0] addr);
      return (int'(addr) >= DEPTH);
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, combinational in the request cycle.
// last_grant resets to M1 so M0 wins the first contention.
module rr_arbiter_2
   import onchip_ram_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   port_e      last_grant_r;
   logic [1:0] grant_s;

   // Grant selection: a lone requester always wins, contention goes to the other port.
   always_comb begin
      grant_s = 2'b00;
      case (req)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = (last_grant_r == PORT_M1) ? 2'b01 : 2'b10;
         default: grant_s = 2'b00;
      endcase
   end

   // Last-grant history, updated on every cycle that grants someone.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_r <= PORT_M1;
      end else if (grant_s[1]) begin
         last_grant_r <= PORT_M1;
      end else if (grant_s[0]) begin
         last_grant_r <= PORT_M0;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM masters: round-robin grant,
// one access per cycle, read-tag pipeline for the 1-cycle read latency, out-of-range guard.
module onchip_ram_arbiter
   import onchip_ram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic [1:0]        req_s;
   logic [1:0]        grant_s;
   logic              any_grant_s;
   logic              oor_s;
   logic              read_accept_s;
   logic [ADDR_W-1:0] sel_address_s;
   logic [BE_W-1:0]   sel_byteenable_s;
   logic [DATA_W-1:0] sel_writedata_s;
   logic              sel_read_s;
   logic              sel_write_s;
   logic [DATA_W-1:0] readdata_s;
   rd_tag_t           rd_tag_r;

   // Nobody is granted while reset is held.
   assign req_s = reset ? 2'b00 : {(m1_read | m1_write), (m0_read | m0_write)};

   rr_arbiter_2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req_s),
      .grant (grant_s)
   );

   // Request mux towards the RAM; m0 drives the don't-care fields when idle.
   always_comb begin
      sel_address_s    = m0_address;
      sel_byteenable_s = m0_byteenable;
      sel_writedata_s  = m0_writedata;
      sel_read_s       = m0_read;
      sel_write_s      = m0_write;
      if (grant_s[1]) begin
         sel_address_s    = m1_address;
         sel_byteenable_s = m1_byteenable;
         sel_writedata_s  = m1_writedata;
         sel_read_s       = m1_read;
         sel_write_s      = m1_write;
      end else begin
         sel_address_s    = m0_address;
         sel_byteenable_s = m0_byteenable;
         sel_writedata_s  = m0_writedata;
         sel_read_s       = m0_read;
         sel_write_s      = m0_write;
      end
   end

   assign any_grant_s    = |grant_s;
   assign oor_s          = addr_oor(sel_address_s);
   // Write wins over a simultaneous (illegal) read on the same port.
   assign read_accept_s  = any_grant_s & sel_read_s & ~sel_write_s;

   assign ram_address    = sel_address_s;
   assign ram_byteenable = sel_byteenable_s;
   assign ram_writedata  = sel_writedata_s;
   assign ram_chipselect = any_grant_s & ~oor_s;
   assign ram_write      = any_grant_s & ~oor_s & sel_write_s;
   assign ram_clken      = 1'b1;

   // Read-tag pipeline: remembers who issued the read one cycle ago and whether it was in range.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_tag_r <= '0;
      end else begin
         rd_tag_r.vld  <= read_accept_s;
         rd_tag_r.port <= grant_s[1] ? PORT_M1 : PORT_M0;
         rd_tag_r.oor  <= oor_s;
      end
   end

   assign readdata_s       = rd_tag_r.oor ? {DATA_W{1'b0}} : ram_readdata;
   assign m0_readdata      = readdata_s;
   assign m1_readdata      = readdata_s;
   // Gating with reset kills a read accepted just before reset asserts.
   assign m0_readdatavalid = ~reset & rd_tag_r.vld & (rd_tag_r.port == PORT_M0);
   assign m1_readdatavalid = ~reset & rd_tag_r.vld & (rd_tag_r.port == PORT_M1);
   assign m0_waitrequest   = reset | (req_s[0] & ~grant_s[0]);
   assign m1_waitrequest   = reset | (req_s[1] & ~grant_s[1]);

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_onchip_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [12:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata = 32'd0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   tests  = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   g0, g1, n0, n1;

   bit [31:0] mem [0:5119];
   bit        loaded = 1'b0;

   onchip_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model; addresses alias modulo the depth so a leaked out-of-range write corrupts real data.
   always @(posedge clk) begin
      if (!loaded) begin
         mem[0]     <= 32'hCAFEF00D;
         mem[16]    <= 32'hDEADBEEF;
         mem[17]    <= 32'h12345678;
         mem[32]    <= 32'h00000000;
         for (int i = 0; i < 4; i++) begin
            mem[256 + i] <= 32'hA0000000 + 32'(i);
            mem[512 + i] <= 32'hB0000000 + 32'(i);
         end
         loaded <= 1'b1;
      end else if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[int'(ram_address) % 5120][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= mem[int'(ram_address) % 5120];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every readdatavalid must match the next queued expectation.
   always @(negedge clk) begin
      if (m0_readdatavalid) begin
         if (q0.size() == 0) begin
            tests++; errors++;
            $display("FAIL m0_spurious_valid: got valid data %h, expected no valid (cycle %0d)", m0_readdata, cyc);
         end else begin
            e0 = q0.pop_front();
            chk("m0_rdata", m0_readdata, e0.data);
            chk("m0_rlatency", 32'(cyc), 32'(e0.due));
         end
      end
      if (m1_readdatavalid) begin
         if (q1.size() == 0) begin
            tests++; errors++;
            $display("FAIL m1_spurious_valid: got valid data %h, expected no valid (cycle %0d)", m1_readdata, cyc);
         end else begin
            e1 = q1.pop_front();
            chk("m1_rdata", m1_readdata, e1.data);
            chk("m1_rlatency", 32'(cyc), 32'(e1.due));
         end
      end
   end

   task automatic set_m0(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [31:0] d);
      q0.push_back('{data: d, due: cyc + 1});
   endtask

   task automatic push1(input logic [31:0] d);
      q1.push_back('{data: d, due: cyc + 1});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_m0_wait"}, {31'd0, m0_waitrequest}, 32'd1);
      chk({tag, "_m1_wait"}, {31'd0, m1_waitrequest}, 32'd1);
      chk({tag, "_cs"}, {31'd0, ram_chipselect}, 32'd0);
      chk({tag, "_wr"}, {31'd0, ram_write}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_m0(1'b1, 1'b0, 13'h010, 4'hF, 32'd0);
      set_m1(1'b1, 1'b0, 13'h011, 4'hF, 32'd0);
      // Reset state with both ports pushing requests
      for (int i = 0; i < 3; i++) begin
         next();
         @(negedge clk);
         chk_reset_outputs("rst");
      end
      chk("rst_clken", {31'd0, ram_clken}, 32'd1);

      // Test 2: contention in the first cycle after reset
      next();
      reset = 1'b0;
      @(negedge clk);
      chk("t2_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("t2_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("t2_addr0", {19'd0, ram_address}, 32'h010);
      push0(32'hDEADBEEF);
      next();
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      @(negedge clk);
      chk("t2_m1_wait2", {31'd0, m1_waitrequest}, 32'd0);
      chk("t2_addr1", {19'd0, ram_address}, 32'h011);
      push1(32'h12345678);
      next();
      set_m1(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      @(negedge clk);
      chk("t2_idle_cs", {31'd0, ram_chipselect}, 32'd0);

      // Test 1: single read by m0
      next();
      set_m0(1'b1, 1'b0, 13'h010, 4'hF, 32'd0);
      @(negedge clk);
      chk("t1_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("t1_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
      push0(32'hDEADBEEF);
      next();
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);

      // Test 3: byte-lane write by m1 then read back by m0
      next();
      set_m1(1'b0, 1'b1, 13'h020, 4'h4, 32'h11223344);
      @(negedge clk);
      chk("t3_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
      chk("t3_ram_write", {31'd0, ram_write}, 32'd1);
      chk("t3_ram_be", {28'd0, ram_byteenable}, 32'h4);
      next();
      set_m1(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      set_m0(1'b1, 1'b0, 13'h020, 4'hF, 32'd0);
      @(negedge clk);
      push0(32'h00220000);
      next();
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);

      // Test 4: out-of-range write dropped, read returns zero, word 0 intact
      next();
      set_m0(1'b0, 1'b1, 13'd5120, 4'hF, 32'hFFFFFFFF);
      @(negedge clk);
      chk("t4_wr_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("t4_wr_cs", {31'd0, ram_chipselect}, 32'd0);
      chk("t4_wr_write", {31'd0, ram_write}, 32'd0);
      next();
      set_m0(1'b1, 1'b0, 13'd5120, 4'hF, 32'd0);
      @(negedge clk);
      chk("t4_rd_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("t4_rd_cs", {31'd0, ram_chipselect}, 32'd0);
      push0(32'h00000000);
      next();
      set_m0(1'b1, 1'b0, 13'd0, 4'hF, 32'd0);
      @(negedge clk);
      chk("t4_rd0_cs", {31'd0, ram_chipselect}, 32'd1);
      push0(32'hCAFEF00D);
      next();
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);

      // Test 5: read in flight when reset asserts must not complete
      next();
      set_m0(1'b1, 1'b0, 13'h010, 4'hF, 32'd0);
      @(negedge clk);
      chk("t5_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      next();
      reset = 1'b1;
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      set_m1(1'b1, 1'b0, 13'h011, 4'hF, 32'd0);
      @(negedge clk);
      chk_reset_outputs("t5");
      chk("t5_m0_valid", {31'd0, m0_readdatavalid}, 32'd0);
      next();
      set_m1(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      @(negedge clk);
      chk_reset_outputs("t5b");

      // Test 6: continuous contention alternates grants, starting with m0
      g0 = 0; g1 = 0; n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
         next();
         if (k == 0) reset = 1'b0;
         set_m0(1'b1, 1'b0, 13'h100 + 13'(n0), 4'hF, 32'd0);
         set_m1(1'b1, 1'b0, 13'h200 + 13'(n1), 4'hF, 32'd0);
         @(negedge clk);
         chk("t6_cs", {31'd0, ram_chipselect}, 32'd1);
         if (!m0_waitrequest) g0++;
         if (!m1_waitrequest) g1++;
         if (k % 2 == 0) begin
            chk("t6_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
            chk("t6_addr", {19'd0, ram_address}, 32'h100 + 32'(n0));
            push0(32'hA0000000 + 32'(n0));
            n0++;
         end else begin
            chk("t6_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
            chk("t6_addr", {19'd0, ram_address}, 32'h200 + 32'(n1));
            push1(32'hB0000000 + 32'(n1));
            n1++;
         end
      end
      next();
      set_m0(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      set_m1(1'b0, 1'b0, 13'h000, 4'h0, 32'd0);
      chk("t6_grants_m0", 32'(g0), 32'd4);
      chk("t6_grants_m1", 32'(g1), 32'd4);

      repeat (3) next();
      @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
